// File: rtl/fc_func_pkg.sv
// Shared types and derived-width helpers for the FC func streaming unit.
package fc_func_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_fc_func_state;

    typedef enum logic [1:0] {
        RELU_TRUNC     = 2'd0,
        RELU_SAT       = 2'd1,
        RELU_SHIFT_SAT = 2'd2,
        RESERVED       = 2'd3
    } t_act_mode;

    // Binary (1-bit) activations carry only the popcount in the obuf.
    function automatic int obuf_data_size(input int data_size, input int xbar_size);
        return (data_size == 1) ? $clog2(xbar_size) : 2 * data_size + $clog2(xbar_size);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // One extra bit beyond the tile-sum growth keeps the signed sum overflow-free.
    function automatic int acc_width(input int obuf_w, input int v_tiles);
        return obuf_w + $clog2(v_tiles) + 1;
    endfunction

    function automatic int addr_width(input int num_addr);
        return (num_addr <= 1) ? 1 : $clog2(num_addr);
    endfunction

    function automatic int shift_width(input int acc_w);
        return (acc_w <= 1) ? 1 : $clog2(acc_w);
    endfunction

endpackage

// File: rtl/fc_func_stream_if.sv
// Obuf read port, next-buffer write port and start/ready handshake of fc_func_stream.
interface fc_func_stream_if #(
    parameter int DATA_SIZE      = 8,
    parameter int INPUT_NEURONS  = 128,
    parameter int OUTPUT_NEURONS = 512,
    parameter int XBAR_SIZE      = 256,
    parameter int OBUF_BUS_WIDTH = 46
);
    import fc_func_pkg::*;

    localparam int OBUF_DATA_SIZE    = obuf_data_size(DATA_SIZE, XBAR_SIZE);
    localparam int NUM_CHANNELS      = OBUF_BUS_WIDTH / OBUF_DATA_SIZE;
    localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE;
    localparam int NUM_ADDR          = ceil_div(ELEMENTS_PER_TILE, NUM_CHANNELS);
    localparam int H_CIM_TILES       = ceil_div(OUTPUT_NEURONS, ELEMENTS_PER_TILE);
    localparam int V_CIM_TILES       = ceil_div(INPUT_NEURONS, XBAR_SIZE);
    localparam int ACC_WIDTH         = acc_width(OBUF_DATA_SIZE, V_CIM_TILES);
    localparam int AW                = addr_width(NUM_ADDR);
    localparam int SHIFT_W           = shift_width(ACC_WIDTH);

    logic                             i_start;
    logic                             o_ready;
    logic                             i_cim_ready;
    logic [1:0]                       i_mode;
    logic [SHIFT_W-1:0]               i_shift;
    logic signed [OBUF_DATA_SIZE-1:0] i_data [H_CIM_TILES][NUM_CHANNELS][V_CIM_TILES];
    logic [AW-1:0]                    o_addr;
    logic [DATA_SIZE-1:0]             o_data [H_CIM_TILES*NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]          o_lane_valid;
    logic [AW-1:0]                    o_wr_addr;
    logic                             o_write_enable;
    logic                             i_next_ready;
    logic                             o_start;

    modport master (
        input  i_start, i_cim_ready, i_mode, i_shift, i_data, i_next_ready,
        output o_ready, o_addr, o_data, o_lane_valid, o_wr_addr, o_write_enable, o_start
    );

    modport slave (
        output i_start, i_cim_ready, i_mode, i_shift, i_data, i_next_ready,
        input  o_ready, o_addr, o_data, o_lane_valid, o_wr_addr, o_write_enable, o_start
    );

endinterface

// File: rtl/fc_act_unit.sv
// Combinational single-element activation: ReLU with truncation, saturation or shift+saturation.
module fc_act_unit #(
    parameter int ACC_WIDTH = 25,
    parameter int DATA_SIZE = 8
) (
    input  logic signed [ACC_WIDTH-1:0]                      acc_i,
    input  fc_func_pkg::t_act_mode                           mode_i,
    input  logic [fc_func_pkg::shift_width(ACC_WIDTH)-1:0]   shift_i,
    output logic [DATA_SIZE-1:0]                             res_o
);
    import fc_func_pkg::*;

    localparam logic signed [ACC_WIDTH-1:0] MAX_VAL =
        {{(ACC_WIDTH-DATA_SIZE){1'b0}}, {DATA_SIZE{1'b1}}};

    function automatic logic [DATA_SIZE-1:0] relu_trunc(input logic signed [ACC_WIDTH-1:0] a);
        return (a <= 0) ? '0 : a[DATA_SIZE-1:0];
    endfunction

    function automatic logic [DATA_SIZE-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] a);
        if (a <= 0)
            return '0;
        else if (a > MAX_VAL)
            return '1;
        else
            return a[DATA_SIZE-1:0];
    endfunction

    // Arithmetic shift floors toward minus infinity, so small negatives stay negative.
    logic signed [ACC_WIDTH-1:0] shifted;
    assign shifted = acc_i >>> shift_i;

    // Select the activation; the reserved mode falls back to plain saturation.
    always_comb begin
        res_o = relu_sat(acc_i);
        case (mode_i)
            RELU_TRUNC:     res_o = relu_trunc(acc_i);
            RELU_SHIFT_SAT: res_o = relu_sat(shifted);
            default:        res_o = relu_sat(acc_i);
        endcase
    end

endmodule

// File: rtl/fc_func_stream.sv
// Streams a layer's CIM output buffer through tile summation and activation into the next input buffer.
module fc_func_stream #(
    parameter int DATA_SIZE      = 8,
    parameter int INPUT_NEURONS  = 128,
    parameter int OUTPUT_NEURONS = 512,
    parameter int XBAR_SIZE      = 256,
    parameter int OBUF_BUS_WIDTH = 46
) (
    input logic              clk,
    input logic              rst_n,
    fc_func_stream_if.master bus
);
    import fc_func_pkg::*;

    localparam int OBUF_DATA_SIZE    = obuf_data_size(DATA_SIZE, XBAR_SIZE);
    localparam int NUM_CHANNELS      = OBUF_BUS_WIDTH / OBUF_DATA_SIZE;
    localparam int ELEMENTS_PER_TILE = XBAR_SIZE / DATA_SIZE;
    localparam int NUM_ADDR          = ceil_div(ELEMENTS_PER_TILE, NUM_CHANNELS);
    localparam int H_CIM_TILES       = ceil_div(OUTPUT_NEURONS, ELEMENTS_PER_TILE);
    localparam int V_CIM_TILES       = ceil_div(INPUT_NEURONS, XBAR_SIZE);
    localparam int ACC_WIDTH         = acc_width(OBUF_DATA_SIZE, V_CIM_TILES);
    localparam int LAST_LANES        = ELEMENTS_PER_TILE - (NUM_ADDR - 1) * NUM_CHANNELS;
    localparam int AW                = addr_width(NUM_ADDR);
    localparam int SHIFT_W           = shift_width(ACC_WIDTH);
    localparam int NLANES            = H_CIM_TILES * NUM_CHANNELS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ADDR - 1);

    function automatic logic signed [ACC_WIDTH-1:0] sext_acc(input logic signed [OBUF_DATA_SIZE-1:0] x);
        return {{(ACC_WIDTH-OBUF_DATA_SIZE){x[OBUF_DATA_SIZE-1]}}, x};
    endfunction

    t_fc_func_state          state_q, state_d;
    logic [AW-1:0]           addr_q, addr_d;
    t_act_mode               mode_q, mode_d;
    logic [SHIFT_W-1:0]      shift_q, shift_d;
    logic                    stall;

    logic signed [ACC_WIDTH-1:0] acc_d [NLANES];
    logic [NUM_CHANNELS-1:0]     mask_d;
    logic signed [ACC_WIDTH-1:0] acc_p1_q [NLANES];
    logic                        vld_p1_q;
    logic [AW-1:0]               tag_p1_q;
    logic [NUM_CHANNELS-1:0]     mask_p1_q;

    logic [DATA_SIZE-1:0]        act_res [NLANES];
    logic [DATA_SIZE-1:0]        data_p2_d [NLANES];
    logic [NUM_CHANNELS-1:0]     lane_p2_d;
    logic [DATA_SIZE-1:0]        data_p2_q [NLANES];
    logic                        vld_p2_q;
    logic [AW-1:0]               tag_p2_q;
    logic [NUM_CHANNELS-1:0]     lane_p2_q;

    // A presented write that the next module refuses freezes the whole pipe.
    assign stall = vld_p2_q && !bus.i_next_ready;

    // Next-state logic: accept, address sequencing and drain.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (bus.i_start && bus.i_cim_ready && bus.i_next_ready) begin
                    state_d = READ;
                    addr_d  = '0;
                    mode_d  = t_act_mode'(bus.i_mode);
                    shift_d = bus.i_shift;
                end
            end
            READ: begin
                if (!stall) begin
                    if (addr_q == LAST_ADDR)
                        state_d = DRAIN;
                    else
                        addr_d = addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (!vld_p1_q && !vld_p2_q)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mode_q  <= RELU_TRUNC;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
        end
    end

    // ---- stage 0 -> 1: sum the vertical tiles and build the lane mask ----
    // Sign-extended sum of each lane's vertical partials.
    always_comb begin
        for (int i = 0; i < H_CIM_TILES; i++) begin
            for (int j = 0; j < NUM_CHANNELS; j++) begin
                acc_d[i*NUM_CHANNELS+j] = '0;
                for (int k = 0; k < V_CIM_TILES; k++) begin
                    acc_d[i*NUM_CHANNELS+j] = acc_d[i*NUM_CHANNELS+j] + sext_acc(bus.i_data[i][j][k]);
                end
            end
        end
    end

    // Only the final address is short; it keeps the low LAST_LANES channels.
    always_comb begin
        for (int j = 0; j < NUM_CHANNELS; j++) begin
            mask_d[j] = (addr_q != LAST_ADDR) || (j < LAST_LANES);
        end
    end

    // Stage-1 accumulator datapath register (no reset needed on data).
    always_ff @(posedge clk) begin
        if (!stall) begin
            acc_p1_q <= acc_d;
        end
    end

    // ---- stage 1 -> 2: activation and masking into the write register ----
    for (genvar n = 0; n < NLANES; n++) begin : g_act
        fc_act_unit #(
            .ACC_WIDTH (ACC_WIDTH),
            .DATA_SIZE (DATA_SIZE)
        ) u_act (
            .acc_i   (acc_p1_q[n]),
            .mode_i  (mode_q),
            .shift_i (shift_q),
            .res_o   (act_res[n])
        );
    end

    // Masked or empty lanes are forced to zero.
    always_comb begin
        for (int i = 0; i < H_CIM_TILES; i++) begin
            for (int j = 0; j < NUM_CHANNELS; j++) begin
                data_p2_d[i*NUM_CHANNELS+j] = '0;
                if (vld_p1_q && mask_p1_q[j])
                    data_p2_d[i*NUM_CHANNELS+j] = act_res[i*NUM_CHANNELS+j];
            end
        end
        lane_p2_d = vld_p1_q ? mask_p1_q : '0;
    end

    // Pipe valids, tags, masks and write data; all hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q  <= 1'b0;
            tag_p1_q  <= '0;
            mask_p1_q <= '0;
            vld_p2_q  <= 1'b0;
            tag_p2_q  <= '0;
            lane_p2_q <= '0;
            for (int n = 0; n < NLANES; n++) data_p2_q[n] <= '0;
        end else if (!stall) begin
            vld_p1_q  <= (state_q == READ);
            tag_p1_q  <= addr_q;
            mask_p1_q <= mask_d;
            vld_p2_q  <= vld_p1_q;
            tag_p2_q  <= tag_p1_q;
            lane_p2_q <= lane_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    assign bus.o_ready        = (state_q == IDLE);
    assign bus.o_start        = (state_q == DONE);
    assign bus.o_addr         = addr_q;
    assign bus.o_data         = data_p2_q;
    assign bus.o_lane_valid   = lane_p2_q;
    assign bus.o_wr_addr      = tag_p2_q;
    assign bus.o_write_enable = vld_p2_q;

endmodule

// File: tb/tb_fc_func_stream.sv
// Directed bench for fc_func_stream: activation vectors, stall, ignored starts and mid-run reset.
module tb_fc_func_stream;

    localparam int DS    = 8;
    localparam int IN_N  = 512;
    localparam int OUT_N = 64;
    localparam int XB    = 256;
    localparam int BW    = 72;
    // Derived by hand: obuf width 24, 3 channels, 32 elements/tile, 11 addresses,
    // 2 horizontal and 2 vertical tiles, acc width 26, shift width 5, 2 lanes on the last address.
    localparam int NCH = 3;
    localparam int NA  = 11;
    localparam int H   = 2;
    localparam int NL  = 6;
    localparam int SHW = 5;
    localparam logic [NCH-1:0] LAST_MASK = 3'b011;

    logic clk;
    logic rst_n;

    fc_func_stream_if #(
        .DATA_SIZE(DS), .INPUT_NEURONS(IN_N), .OUTPUT_NEURONS(OUT_N),
        .XBAR_SIZE(XB), .OBUF_BUS_WIDTH(BW)
    ) bus ();

    fc_func_stream #(
        .DATA_SIZE(DS), .INPUT_NEURONS(IN_N), .OUTPUT_NEURONS(OUT_N),
        .XBAR_SIZE(XB), .OBUF_BUS_WIDTH(BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         shift;
        int         p0;
        int         p1;
        int         expv;
    } vec_t;

    vec_t vt [18];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   p0 = 0, p1 = 0, exp_val = 0;
    bit   ramp = 1'b0;
    bit   mon_en = 1'b0;
    int   exp_tag = 0;
    int   n_wr = 0;
    int   wr_seen = 0;
    logic [DS-1:0] snap_data [NL];
    logic [3:0]    snap_addr;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Obuf model: uniform partials, or a per-address ramp in tile 0.
    always_comb begin
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < NCH; j++) begin
                if (ramp) begin
                    bus.i_data[i][j][0] = 24'(int'(bus.o_addr) * 3 + i * NCH + j);
                    bus.i_data[i][j][1] = '0;
                end else begin
                    bus.i_data[i][j][0] = 24'(p0);
                    bus.i_data[i][j][1] = 24'(p1);
                end
            end
        end
    end

    // Write scoreboard: every completed write is checked against the expected tag order.
    always @(negedge clk) begin
        if (rst_n && bus.o_write_enable && bus.i_next_ready) begin
            wr_seen++;
            if (mon_en) begin
                check("wr_tag", int'(bus.o_wr_addr), exp_tag);
                check("lane_valid", int'(bus.o_lane_valid), (exp_tag == NA - 1) ? int'(LAST_MASK) : 7);
                for (int i = 0; i < H; i++) begin
                    for (int j = 0; j < NCH; j++) begin
                        int e;
                        if (exp_tag == NA - 1 && j >= 2) e = 0;
                        else if (ramp) e = exp_tag * 3 + i * NCH + j;
                        else e = exp_val;
                        check("o_data", int'(bus.o_data[i*NCH+j]), e);
                    end
                end
                exp_tag++;
                n_wr++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, int'(bus.o_ready), 1);
        check({tag, "_addr"}, int'(bus.o_addr), 0);
        check({tag, "_wr_addr"}, int'(bus.o_wr_addr), 0);
        check({tag, "_lane_valid"}, int'(bus.o_lane_valid), 0);
        check({tag, "_we"}, int'(bus.o_write_enable), 0);
        check({tag, "_start"}, int'(bus.o_start), 0);
        for (int n = 0; n < NL; n++) check({tag, "_data"}, int'(bus.o_data[n]), 0);
    endtask

    task automatic run(input logic [1:0] mode, input int shift, input int a, input int b,
                       input int expv, input bit use_ramp, input bit poke, input bit do_stall);
        int cyc;
        int stall_cnt;
        p0 = a; p1 = b; ramp = use_ramp; exp_val = expv;
        exp_tag = 0; n_wr = 0; mon_en = 1'b1;
        check("ready_before_start", int'(bus.o_ready), 1);
        bus.i_mode = mode;
        bus.i_shift = SHW'(shift);
        bus.i_cim_ready = 1'b1;
        bus.i_next_ready = 1'b1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_mode = ~mode;
        bus.i_shift = '0;
        bus.i_cim_ready = 1'b0;
        cyc = 0;
        stall_cnt = 0;
        while (!bus.o_start && cyc < 200) begin
            bus.i_start = poke && (cyc == 3);
            if (stall_cnt >= 1 && stall_cnt <= 3) begin
                check("stall_we", int'(bus.o_write_enable), 1);
                check("stall_wr_addr", int'(bus.o_wr_addr), 1);
                check("stall_o_addr", int'(bus.o_addr), int'(snap_addr));
                for (int n = 0; n < NL; n++) check("stall_data", int'(bus.o_data[n]), int'(snap_data[n]));
            end
            if (do_stall && stall_cnt < 3 && bus.o_write_enable && bus.o_wr_addr == 4'd1) begin
                if (stall_cnt == 0) begin
                    snap_data = bus.o_data;
                    snap_addr = bus.o_addr;
                end
                bus.i_next_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.i_next_ready = 1'b1;
                if (stall_cnt == 3) stall_cnt = 4;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.i_start = 1'b0;
        bus.i_next_ready = 1'b1;
        check("start_latency", cyc, NA + 3 + (do_stall ? 3 : 0));
        if (do_stall) check("stall_seen", stall_cnt, 4);
        @(posedge clk); #1;
        check("start_one_cycle", int'(bus.o_start), 0);
        check("idle_after_done", int'(bus.o_ready), 1);
        @(posedge clk); #1;
        check("no_restart_we", int'(bus.o_write_enable), 0);
        check("write_count", n_wr, NA);
        mon_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{2'd1, 0, 100, 0, 100};
        vt[1]  = '{2'd0, 0, 200, 100, 44};
        vt[2]  = '{2'd1, 0, 200, 100, 255};
        vt[3]  = '{2'd2, 2, 200, 100, 75};
        vt[4]  = '{2'd3, 0, 200, 100, 255};
        vt[5]  = '{2'd0, 0, -5, 2, 0};
        vt[6]  = '{2'd1, 0, -5, 2, 0};
        vt[7]  = '{2'd2, 0, -5, 2, 0};
        vt[8]  = '{2'd2, 4, -1, 0, 0};
        vt[9]  = '{2'd1, 0, 255, 0, 255};
        vt[10] = '{2'd1, 0, 200, 56, 255};
        vt[11] = '{2'd0, 0, 256, 0, 0};
        vt[12] = '{2'd0, 0, 8388607, 8388607, 254};
        vt[13] = '{2'd2, 16, 8388607, 8388607, 255};
        vt[14] = '{2'd2, 1, -8388608, -8388608, 0};
        vt[15] = '{2'd0, 0, 0, 0, 0};
        vt[16] = '{2'd0, 0, 1, 0, 1};
        vt[17] = '{2'd2, 3, 50, 50, 12};

        bus.i_start = 1'b0;
        bus.i_cim_ready = 1'b0;
        bus.i_mode = 2'd0;
        bus.i_shift = '0;
        bus.i_next_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 18; v++) begin
            run(vt[v].mode, vt[v].shift, vt[v].p0, vt[v].p1, vt[v].expv, 1'b0, 1'b0, 1'b0);
        end

        // Back-pressure on the second write with address-dependent data.
        run(2'd1, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);

        // Start pulsed while reading is ignored.
        run(2'd1, 0, 100, 0, 100, 1'b0, 1'b1, 1'b0);

        // Start without obuf ready is not accepted.
        begin
            int seen0;
            seen0 = wr_seen;
            bus.i_cim_ready = 1'b0;
            bus.i_start = 1'b1;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            for (int c = 0; c < 4; c++) begin
                check("no_cim_ready_idle", int'(bus.o_ready), 1);
                @(posedge clk); #1;
            end
            check("no_cim_writes", wr_seen - seen0, 0);
        end

        // Reset in the middle of READ aborts the run.
        begin
            p0 = 100; p1 = 0; ramp = 1'b0;
            bus.i_mode = 2'd1;
            bus.i_cim_ready = 1'b1;
            bus.i_start = 1'b1;
            @(posedge clk); #1;
            bus.i_start = 1'b0;
            bus.i_cim_ready = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            check("busy_in_read", int'(bus.o_ready), 0);
            check("we_in_read", int'(bus.o_write_enable), 1);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrun_reset");
            @(posedge clk); #1;
            check_reset_outputs("held_reset");
            #2 rst_n = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                check("abort_no_start", int'(bus.o_start), 0);
                check("abort_idle", int'(bus.o_ready), 1);
            end
        end

        // Clean run after the abort starts from address 0.
        run(vt[3].mode, vt[3].shift, vt[3].p0, vt[3].p1, vt[3].expv, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
